// File: rtl/mcu_spi_pkg.sv
// Shared definitions for the MCU SPI target: endpoint codes, FSM states, reply mux.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package mcu_spi_pkg;

    localparam logic [1:0] TGT_SYS = 2'd0;
    localparam logic [1:0] TGT_HID = 2'd1;
    localparam logic [1:0] TGT_OSD = 2'd2;
    localparam logic [1:0] TGT_SDC = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        PAYLOAD = 2'd2,
        DISCARD = 2'd3
    } spi_state_t;

    // Picks the reply byte of the endpoint addressed by the frame's select byte.
    function automatic logic [7:0] reply_mux(
        input logic [1:0] sel,
        input logic [7:0] d_sys,
        input logic [7:0] d_hid,
        input logic [7:0] d_osd,
        input logic [7:0] d_sdc
    );
        logic [7:0] r;
        case (sel)
            TGT_SYS: r = d_sys;
            TGT_HID: r = d_hid;
            TGT_OSD: r = d_osd;
            default: r = d_sdc;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous pin plus single-clk rise/fall pulses.
// Latency: pulses appear SYNC_STAGES clk after the raw edge.
// Backpressure: none; every edge yields exactly one pulse.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    // Shift the pin through the synchroniser and remember last synchronised level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/mcu_spi_target.sv
// SPI mode-0 target: select byte routes payload bytes to one endpoint, endpoint reply goes out on MISO.
// Latency: data_strobe SYNC_STAGES+1 clk after the raw 8th sclk rise; MISO within SYNC_STAGES+1 clk of sclk fall.
// Backpressure: none; endpoints must accept a strobe every clk it is issued.
module mcu_spi_target
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sclk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       data_strobe,
    output logic       data_start,
    output logic [7:0] data_byte,
    output logic [1:0] target,
    output logic       target_valid,
    input  logic [7:0] din_sys,
    input  logic [7:0] din_hid,
    input  logic [7:0] din_osd,
    input  logic [7:0] din_sdc
);

    logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;
    spi_state_t             state_q, state_nxt;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             shift_q;
    logic [7:0]             tx_q;
    logic [7:0]             rx_byte;
    logic [1:0]             sel_q;
    logic                   first_q;
    logic                   frame_open;
    logic                   byte_done;
    logic                   sel_legal;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_csn),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    // MOSI needs the same delay as sclk so the rise pulse sees the matching bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // csn high always parks the FSM in IDLE, so "not IDLE" means csn is low.
    assign frame_open = (state_q != IDLE);
    assign byte_done  = frame_open && sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte    = {shift_q, mosi_s};
    assign sel_legal  = (rx_byte[7:2] == 6'd0);

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state: csn edges win over anything sclk does in the same clk.
    always_comb begin
        state_nxt = state_q;
        if (csn_rise) begin
            state_nxt = IDLE;
        end else if (csn_fall) begin
            state_nxt = SELECT;
        end else if (byte_done && (state_q == SELECT)) begin
            state_nxt = sel_legal ? PAYLOAD : DISCARD;
        end
    end

    // FSM outputs: MISO only driven while the frame may still carry a reply.
    always_comb begin
        target_valid = (state_q == PAYLOAD);
        spi_miso     = ((state_q == SELECT) || (state_q == PAYLOAD)) ? tx_q[7] : 1'b0;
    end

    // Bit/byte datapath: receive shifter, strobe generation and the reply shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            tx_q        <= 8'h00;
            sel_q       <= TGT_SYS;
            first_q     <= 1'b0;
            data_strobe <= 1'b0;
            data_start  <= 1'b0;
            data_byte   <= 8'h00;
            target      <= TGT_SYS;
        end else begin
            data_strobe <= 1'b0;
            data_start  <= 1'b0;
            if (csn_rise || csn_fall) begin
                // Any partial byte is dropped; the select byte always replies 0x00.
                bit_cnt_q <= 3'd0;
                tx_q      <= 8'h00;
                first_q   <= 1'b1;
            end else if (frame_open) begin
                if (sclk_rise) begin
                    shift_q   <= rx_byte[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (byte_done) begin
                        if ((state_q == SELECT) && sel_legal) begin
                            sel_q <= rx_byte[1:0];
                        end
                        if (state_q == PAYLOAD) begin
                            data_byte   <= rx_byte;
                            target      <= sel_q;
                            data_strobe <= 1'b1;
                            data_start  <= first_q;
                            first_q     <= 1'b0;
                        end
                    end
                end
                if (sclk_fall) begin
                    // The fall that closes a byte loads the reply for the next one.
                    if (bit_cnt_q == 3'd0) begin
                        tx_q <= (state_q == PAYLOAD)
                              ? reply_mux(sel_q, din_sys, din_hid, din_osd, din_sdc)
                              : 8'h00;
                    end else begin
                        tx_q <= {tx_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mcu_spi_target.sv
// Bench for mcu_spi_target: MCU-side bit-banged frames checked against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mcu_spi_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sclk, spi_csn, spi_mosi, spi_miso;
    logic       data_strobe, data_start, target_valid;
    logic [7:0] data_byte;
    logic [1:0] target;
    logic [7:0] din_sys, din_hid, din_osd, din_sdc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [10:0] strb_q[$];
    int          strb_t[$];
    int          wide_cnt = 0;
    logic        strobe_prev = 1'b0;

    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_miso_q[$];
    logic [10:0] exp_s_q[$];
    logic        osd_arm;
    logic        tv_s, tv_mid;
    int          last_rise_cyc;

    mcu_spi_target dut (
        .clk          (clk),
        .reset        (reset),
        .spi_sclk     (spi_sclk),
        .spi_csn      (spi_csn),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .data_strobe  (data_strobe),
        .data_start   (data_start),
        .data_byte    (data_byte),
        .target       (target),
        .target_valid (target_valid),
        .din_sys      (din_sys),
        .din_hid      (din_hid),
        .din_osd      (din_osd),
        .din_sdc      (din_sdc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Endpoint-side recorder: every strobe with its qualifiers and arrival cycle.
    always @(negedge clk) begin
        if (data_strobe) begin
            strb_q.push_back({data_start, target, data_byte});
            strb_t.push_back(cyc);
        end
        if (data_strobe && strobe_prev) wide_cnt++;
        strobe_prev = data_strobe;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] din_for(input logic [1:0] s);
        case (s)
            2'd0:    return din_sys;
            2'd1:    return din_hid;
            2'd2:    return din_osd;
            default: return din_sdc;
        endcase
    endfunction

    // Wait n clks; an armed OSD endpoint swaps its reply when it sees a strobe.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (osd_arm && data_strobe) din_osd = 8'hA5;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, input int half, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(half);
            spi_sclk = 1'b1;
            rx[i] = spi_miso;
            if (i == 7) tv_s = target_valid;
            if (i == 0) last_rise_cyc = cyc;
            tick(half);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input int half, input int cut);
        logic [7:0] rx;
        int nb;
        rx_q.delete();
        spi_csn = 1'b0;
        for (int k = 0; k < tx_q.size(); k++) begin
            nb = (k == tx_q.size() - 1 && cut > 0) ? cut : 8;
            spi_byte(tx_q[k], nb, half, rx);
            rx_q.push_back(rx);
            if (k == 1) tv_mid = tv_s;
        end
        tick(half);
        spi_csn = 1'b1;
        tick(4 * half + 4);
    endtask

    // Reply model: select slot is 0x00, later slots carry the addressed endpoint's byte.
    task automatic set_exp_miso(input logic [7:0] d);
        exp_miso_q.delete();
        for (int k = 0; k < tx_q.size(); k++)
            exp_miso_q.push_back((k == 0 || tx_q[0] > 8'd3) ? 8'h00 : d);
    endtask

    task automatic run_check(input string tag, input int half, input int cut, input bit chk_miso);
        int base, n;
        base = strb_q.size();
        n = (cut > 0) ? tx_q.size() - 1 : tx_q.size();
        exp_s_q.delete();
        if (tx_q[0] <= 8'd3)
            for (int k = 1; k < n; k++) exp_s_q.push_back({k == 1, tx_q[0][1:0], tx_q[k]});
        spi_frame(half, cut);
        check({tag, "_nstrobe"}, strb_q.size() - base, exp_s_q.size());
        for (int k = 0; k < exp_s_q.size(); k++)
            if (base + k < strb_q.size()) check({tag, "_strobe"}, strb_q[base + k], exp_s_q[k]);
        if (chk_miso)
            for (int k = 0; k < n; k++) check({tag, "_miso"}, rx_q[k], exp_miso_q[k]);
        if (tx_q.size() > 1) check({tag, "_tvalid_mid"}, tv_mid, tx_q[0] <= 8'd3);
        check({tag, "_tvalid_end"}, target_valid, 1'b0);
        if (cut == 0 && exp_s_q.size() > 0 && strb_q.size() == base + exp_s_q.size())
            check({tag, "_latency"}, strb_t[strb_t.size() - 1] - last_rise_cyc, 3);
    endtask

    initial begin
        logic [7:0] rxb, sel;
        int len;
        reset = 1'b0; spi_sclk = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        din_sys = 8'h00; din_hid = 8'h00; din_osd = 8'h00; din_sdc = 8'h00;
        osd_arm = 1'b0; tv_s = 1'b0; tv_mid = 1'b0; last_rise_cyc = 0;
        tick(3);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_strobe", data_strobe, 1'b0);
        check("rst_start", data_start, 1'b0);
        check("rst_byte", data_byte, 8'h00);
        check("rst_target", target, 2'd0);
        check("rst_tvalid", target_valid, 1'b0);
        reset = 1'b1;
        tick(4);

        // HID frame with constant reply.
        din_hid = 8'h5C;
        tx_q = '{8'h01, 8'h03, 8'h00, 8'h15};
        set_exp_miso(din_hid);
        run_check("hid", 4, 0, 1'b1);

        // Reset in the middle of a payload byte.
        din_hid = 8'hFF;
        spi_csn = 1'b0;
        spi_byte(8'h01, 8, 4, rxb);
        spi_byte(8'h03, 8, 4, rxb);
        spi_byte(8'h0F, 4, 4, rxb);
        check("pre_rst_tvalid", target_valid, 1'b1);
        #3 reset = 1'b0;
        #1;
        check("arst_miso", spi_miso, 1'b0);
        check("arst_byte", data_byte, 8'h00);
        check("arst_target", target, 2'd0);
        check("arst_tvalid", target_valid, 1'b0);
        check("arst_strobe", data_strobe, 1'b0);
        @(negedge clk);
        spi_csn = 1'b1;
        reset = 1'b1;
        tick(8);
        tx_q = '{8'h03, 8'h9E, 8'h41};
        din_sdc = 8'hC3;
        set_exp_miso(din_sdc);
        run_check("post_rst", 4, 0, 1'b1);

        // csn raised after 5 bits of the second payload byte, then a clean frame.
        tx_q = '{8'h01, 8'h11, 8'h22};
        set_exp_miso(din_hid);
        run_check("cut", 4, 5, 1'b1);
        tx_q = '{8'h01, 8'h33};
        set_exp_miso(din_hid);
        run_check("after_cut", 4, 0, 1'b1);

        // Illegal select byte.
        tx_q = '{8'h07, 8'hAA, 8'h55};
        set_exp_miso(8'h00);
        run_check("discard", 4, 0, 1'b1);

        // Back-to-back frames at the minimum clock ratio.
        din_sys = 8'h12;
        tx_q = '{8'h00, 8'h00};
        run_check("b2b_a", 2, 0, 1'b0);
        tx_q = '{8'h03, 8'h01};
        run_check("b2b_b", 2, 0, 1'b0);

        // OSD endpoint updates its reply on the first payload strobe.
        din_osd = 8'h3C;
        tx_q = '{8'h02, 8'h11, 8'h22, 8'h33};
        set_exp_miso(8'h3C);
        exp_miso_q[2] = 8'hA5;
        exp_miso_q[3] = 8'hA5;
        osd_arm = 1'b1;
        run_check("osd", 4, 0, 1'b1);
        osd_arm = 1'b0;

        // Randomised frames.
        for (int f = 0; f < 12; f++) begin
            din_sys = 8'($urandom); din_hid = 8'($urandom);
            din_osd = 8'($urandom); din_sdc = 8'($urandom);
            sel = ($urandom_range(0, 4) == 4) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            len = $urandom_range(1, 4);
            tx_q.delete();
            tx_q.push_back(sel);
            for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
            set_exp_miso(din_for(sel[1:0]));
            run_check("rand", $urandom_range(4, 6), 0, 1'b1);
        end

        check("strobe_width", wide_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
